mul_32_32_64: RTL

- Sequential radix-2 shift-add multiplier: 32-bit x 32-bit -> 64-bit product, signed or unsigned.
- Sits directly upstream of the 64/32 divider in the integer ALU. Produces the 64-bit dividend for multiply-then-divide sequences and the HI/LO product for MULT/MULTU.
- Start/done handshake; one operation in flight at a time.

---
 rtl/mul_32_32_64_if.sv | 23 ++
 rtl/mul_32_32_64.sv | 89 ++++++++
 2 files changed

// File: rtl/mul_32_32_64_if.sv
// Start/done handshake bundle between the ALU sequencer and the shift-add multiplier.
// The master issues operands and start; the slave reports busy, done and the product.
interface mul_32_32_64_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 sign;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   prod;

    modport master (
        output start, sign, a, b,
        input  busy, done, prod
    );

    modport slave (
        input  start, sign, a, b,
        output busy, done, prod
    );
endinterface

// File: rtl/mul_32_32_64.sv
// Sequential radix-2 shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Magnitudes are multiplied over 2^CNT_W CALC cycles; the sign is applied in a single FIX cycle.
module mul_32_32_64 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_32_32_64_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     count;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH:0]     acc;
    logic                 neg;
    logic                 done_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       sum;

    // acc is {carry, acc_hi, acc_lo/mplier}; the multiplier bits are shifted out as product bits shift in
    always_comb begin
        a_mag = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_mag = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        sum   = acc[2*WIDTH:WIDTH] + {1'b0, mcand & {WIDTH{acc[0]}}};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = CALC;
            CALC:    if (count == {CNT_W{1'b1}}) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            mcand  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            done_r <= 1'b0;
            prod_r <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand <= a_mag;
                        acc   <= {{(WIDTH+1){1'b0}}, b_mag};
                        neg   <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        count <= '0;
                    end
                end
                CALC: begin
                    acc   <= {1'b0, sum, acc[WIDTH-1:1]};
                    count <= count + CNT_W'(1);
                end
                FIX: begin
                    prod_r <= neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
                    done_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_r;
    assign bus.prod = prod_r;
endmodule
